uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Sequencer and buffer for the UART receiver. Drives the receiver's s_ticks from a programmable baud divider.
//  Latches the receiver's early correct_send pulse and commits each finished frame to a FIFO as {parity_err, data}.
//  Presents frames to the bus side through a valid/ready stream and keeps sticky overrun and error counters.
// PARAMETERS
//  DATA_W        8      payload bits per frame (receiver Data_bits-1)
//  DEPTH         8      FIFO entries; power of 2, >=2
//  DIV_W         16     width of baud divisor
//  TIMEOUT_TICKS 64     s_ticks periods of idle before rx_timeout (UART_RX_TIMEOUT_EN only)
// PORTS
//  clk           in   1         clock
//  Reset         in   1         asynchronous, active-high reset
//  enable        in   1         1 = baud generator runs
//  baud_div      in   DIV_W     s_ticks period minus 1, in clk cycles
//  clr_status    in   1         1-cycle pulse: clears overrun, frame_cnt, perr_cnt
//  s_ticks       out  1         oversample tick to receiver
//  rx_done_tick  in   1         receiver frame-complete pulse
//  correct_send  in   1         receiver parity-good pulse (precedes rx_done_tick by the stop period)
//  rx_data       in   DATA_W    receiver data_out
//  m_valid       out  1         FIFO head valid
//  m_ready       in   1         consumer accepts head
//  m_data        out  DATA_W    head payload
//  m_perr        out  1         head frame had a parity error
//  overrun       out  1         sticky: a frame was dropped on full FIFO
//  frame_cnt     out  16        saturating count of committed frames
//  perr_cnt      out  8         saturating count of committed frames with parity error
//  rx_timeout    out  1         idle-timeout flag (tied 0 without UART_RX_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: all outputs 0, divider=0, FIFO empty, state CT_IDLE. Reset mid-frame discards the partial frame and all FIFO contents.
//  Baud generator:
//   - div_cnt counts 0..baud_div while enable=1.
//   - s_ticks=1 for exactly one cycle when div_cnt==baud_div; div_cnt then wraps to 0. baud_div=0 -> s_ticks every cycle.
//   - baud_div is sampled only at wrap; changes mid-period take effect next period.
//   - enable=0: div_cnt held at 0, s_ticks=0, FSM and FIFO unaffected.
//  FSM (states in package):
//   - CT_IDLE:  correct_send -> pok_q<=1, go CT_FRAME. rx_done_tick alone -> commit with parity_err=1, stay.
//   - CT_FRAME: rx_done_tick -> commit with parity_err=~pok_q, clear pok_q, go CT_IDLE.
//   - correct_send and rx_done_tick in the same cycle count as a good frame.
//  Commit:
//   - Registered. rx_data is captured on the rx_done_tick cycle; the entry is written the next cycle.
//   - Empty FIFO: m_valid rises 1 cycle after rx_done_tick.
//   - Full FIFO and no pop that cycle: entry dropped, overrun<=1, counters unchanged.
//   - Full FIFO with a pop (m_valid&m_ready) in the same cycle: push accepted.
//  Stream: pop on m_valid&m_ready. m_data and m_perr are stable while m_valid=1 and m_ready=0. Pointers are log2(DEPTH)+1 bits; they wrap naturally.
//  Counters: frame_cnt and perr_cnt increment on an accepted commit and saturate at all-ones.
//  clr_status has priority: a commit in the same cycle is not counted, but is still stored.
// CONFIGURATION
//  UART_RX_TIMEOUT_EN defined:
//   - idle_cnt counts s_ticks while the FIFO is non-empty and the FSM is in CT_IDLE.
//   - idle_cnt resets on any commit, pop or correct_send.
//   - rx_timeout=1 when idle_cnt==TIMEOUT_TICKS; held until a pop, a commit or the FIFO going empty.
//  UART_RX_TIMEOUT_EN undefined: no idle counter; rx_timeout constant 0; port retained.
// STRUCTURE
//  uart_rx_ctrl_pkg:
//   - ct_state_e {CT_IDLE, CT_FRAME}
//   - rx_entry_t struct {logic perr; logic [DATA_W-1:0] data}
//   - localparams for counter widths
//  Sub-module uart_rx_fifo: synchronous FIFO, DEPTH x $bits(rx_entry_t).
//   - Ports push/pop/full/empty/din/dout; first-word fall-through.
//  Top holds the baud divider, FSM, commit register, counters and the timeout logic.
// TESTING
//  1 baud_div=3, enable=1 -> s_ticks period 4 clk, one cycle high; set baud_div=1 mid-period -> new period after next wrap.
//  2 correct_send, then rx_done_tick with rx_data=8'hA5, m_ready=1 -> m_valid 1 cycle later, m_data=A5, m_perr=0, frame_cnt=1.
//  3 rx_done_tick with no prior correct_send, rx_data=8'h3C -> m_perr=1, perr_cnt=1.
//  4 m_ready=0, 9 frames, DEPTH=8 -> 8 stored, overrun=1, frame_cnt=8; drain -> order preserved, first-in first-out.
//  5 FIFO full, commit and pop in same cycle -> push accepted, overrun stays 0; clr_status with commit -> counters 0.
//  6 UART_RX_TIMEOUT_EN, TIMEOUT_TICKS=4, 1 frame held -> rx_timeout after 4 s_ticks; pop clears it. Asserting Reset mid-frame -> all outputs 0.

Source files
------------

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and widths for the UART receive controller.
// Entry layout is {perr, data}.
package uart_rx_ctrl_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned PERR_CNT_W  = 8;

  typedef enum logic {
    CT_IDLE  = 1'b0,
    CT_FRAME = 1'b1
  } ct_state_e;

  typedef struct packed {
    logic              perr;
    logic [DATA_W-1:0] data;
  } rx_entry_t;

  localparam int unsigned ENTRY_W = $bits(rx_entry_t);

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Valid/ready stream carrying received frames to the bus side.
interface uart_rx_ctrl_if;
  import uart_rx_ctrl_pkg::*;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_perr;

  modport master (output m_valid, output m_data, output m_perr, input  m_ready);
  modport slave  (input  m_valid, input  m_data, input  m_perr, output m_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word fall-through synchronous FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 9
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_pop;
  logic         do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[AW'(i)] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: baud tick generator, frame FSM, commit register,
// frame FIFO and status counters. Idle timeout built only with UART_RX_TIMEOUT_EN.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned DIV_W         = 16,
  parameter int unsigned TIMEOUT_TICKS = 64
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic                   enable,
  input  logic [DIV_W-1:0]       baud_div,
  input  logic                   clr_status,
  output logic                   s_ticks,
  input  logic                   rx_done_tick,
  input  logic                   correct_send,
  input  logic [DATA_W-1:0]      rx_data,
  uart_rx_ctrl_if.master         m_if,
  output logic                   overrun,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [PERR_CNT_W-1:0]  perr_cnt,
  output logic                   rx_timeout
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_TICKS == 0) begin : g_bad_param
    $error("uart_rx_ctrl: DEPTH must be a power of 2 >= 2 and TIMEOUT_TICKS >= 1");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_q;
  logic             wrap_c;

  ct_state_e state_q, state_d;
  logic      pok_q, pok_d;
  logic      cmt_fire_c;
  logic      cmt_perr_c;

  rx_entry_t cmt_q;
  logic      cmt_vld_q;
  rx_entry_t head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      pop_c;
  logic      push_acc_c;

  // Baud divider; the divisor is reloaded at each wrap and while disabled
  assign wrap_c = enable & (div_cnt == div_q);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      div_cnt <= '0;
      div_q   <= '0;
      s_ticks <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      div_q   <= baud_div;
      s_ticks <= 1'b0;
    end else if (wrap_c) begin
      div_cnt <= '0;
      div_q   <= baud_div;
      s_ticks <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      s_ticks <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= CT_IDLE;
      pok_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pok_q   <= pok_d;
    end
  end

  // A frame is good if correct_send arrived before or with its rx_done_tick
  always_comb begin
    state_d    = state_q;
    pok_d      = pok_q;
    cmt_fire_c = 1'b0;
    cmt_perr_c = 1'b0;
    case (state_q)
      CT_IDLE: begin
        if (rx_done_tick) begin
          cmt_fire_c = 1'b1;
          cmt_perr_c = ~correct_send;
        end else if (correct_send) begin
          pok_d   = 1'b1;
          state_d = CT_FRAME;
        end
      end
      CT_FRAME: begin
        if (rx_done_tick) begin
          cmt_fire_c = 1'b1;
          cmt_perr_c = ~pok_q;
          pok_d      = 1'b0;
          state_d    = CT_IDLE;
        end
      end
      default: state_d = CT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      cmt_vld_q <= 1'b0;
      cmt_q     <= '0;
    end else begin
      cmt_vld_q <= cmt_fire_c;
      if (cmt_fire_c) begin
        cmt_q.perr <= cmt_perr_c;
        cmt_q.data <= rx_data;
      end
    end
  end

  assign pop_c      = ~fifo_empty & m_if.m_ready;
  assign push_acc_c = cmt_vld_q & (~fifo_full | pop_c);

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .Reset (Reset),
    .push  (cmt_vld_q),
    .pop   (pop_c),
    .din   (cmt_q),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_if.m_valid = ~fifo_empty;
  assign m_if.m_data  = head.data;
  assign m_if.m_perr  = head.perr;

  // clr_status wins over a same-cycle commit or drop
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      overrun   <= 1'b0;
      frame_cnt <= '0;
      perr_cnt  <= '0;
    end else if (clr_status) begin
      overrun   <= 1'b0;
      frame_cnt <= '0;
      perr_cnt  <= '0;
    end else if (push_acc_c) begin
      if (frame_cnt != '1)              frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      if (cmt_q.perr && perr_cnt != '1) perr_cnt  <= perr_cnt + PERR_CNT_W'(1);
    end else if (cmt_vld_q) begin
      overrun <= 1'b1;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned      TO_W   = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TO_W-1:0]  TO_MAX = TO_W'(TIMEOUT_TICKS);

  logic [TO_W-1:0] idle_cnt;

  // Counts baud ticks while data waits in the FIFO and no frame is in flight
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      idle_cnt   <= '0;
      rx_timeout <= 1'b0;
    end else begin
      if (push_acc_c || pop_c || correct_send || fifo_empty)
        idle_cnt <= '0;
      else if (s_ticks && state_q == CT_IDLE && idle_cnt != TO_MAX)
        idle_cnt <= idle_cnt + TO_W'(1);

      if (push_acc_c || pop_c || fifo_empty) rx_timeout <= 1'b0;
      else if (idle_cnt == TO_MAX)           rx_timeout <= 1'b1;
    end
  end
`else
  assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: randomized frames and consumer
// back-pressure checked against a queue-based reference model.
module tb_uart_rx_ctrl;
  import uart_rx_ctrl_pkg::*;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned DIV_W    = 16;
  localparam int unsigned TO_TICKS = 4;

  logic                   clk = 1'b0;
  logic                   Reset;
  logic                   enable;
  logic [DIV_W-1:0]       baud_div;
  logic                   clr_status;
  logic                   s_ticks;
  logic                   rx_done_tick;
  logic                   correct_send;
  logic [DATA_W-1:0]      rx_data;
  logic                   overrun;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic [PERR_CNT_W-1:0]  perr_cnt;
  logic                   rx_timeout;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(
    .DEPTH         (DEPTH),
    .DIV_W         (DIV_W),
    .TIMEOUT_TICKS (TO_TICKS)
  ) dut (
    .clk          (clk),
    .Reset        (Reset),
    .enable       (enable),
    .baud_div     (baud_div),
    .clr_status   (clr_status),
    .s_ticks      (s_ticks),
    .rx_done_tick (rx_done_tick),
    .correct_send (correct_send),
    .rx_data      (rx_data),
    .m_if         (bus),
    .overrun      (overrun),
    .frame_cnt    (frame_cnt),
    .perr_cnt     (perr_cnt),
    .rx_timeout   (rx_timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: ordered queue of {perr,data}, plus status counters
  logic [8:0] mq[$];
  bit         pend;
  logic [8:0] pend_e;
  bit         seen_cs;
  int         m_fcnt;
  int         m_pcnt;
  bit         m_ovr;

  task automatic reset_model();
    mq.delete();
    pend    = 1'b0;
    pend_e  = '0;
    seen_cs = 1'b0;
    m_fcnt  = 0;
    m_pcnt  = 0;
    m_ovr   = 1'b0;
  endtask

  task automatic check_outputs();
    logic [8:0] h;
    check_eq("m_valid", 32'(bus.m_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      h = mq[0];
      check_eq("m_data", 32'(bus.m_data), 32'(h[7:0]));
      check_eq("m_perr", 32'(bus.m_perr), 32'(h[8]));
    end
    check_eq("overrun",   32'(overrun),   32'(m_ovr));
    check_eq("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    check_eq("perr_cnt",  32'(perr_cnt),  32'(m_pcnt));
`ifndef UART_RX_TIMEOUT_EN
    check_eq("rx_timeout_tied", 32'(rx_timeout), 32'(0));
`endif
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, ".s_ticks"},    32'(s_ticks),     32'(0));
    check_eq({tag, ".m_valid"},    32'(bus.m_valid), 32'(0));
    check_eq({tag, ".m_data"},     32'(bus.m_data),  32'(0));
    check_eq({tag, ".m_perr"},     32'(bus.m_perr),  32'(0));
    check_eq({tag, ".overrun"},    32'(overrun),     32'(0));
    check_eq({tag, ".frame_cnt"},  32'(frame_cnt),   32'(0));
    check_eq({tag, ".perr_cnt"},   32'(perr_cnt),    32'(0));
    check_eq({tag, ".rx_timeout"}, 32'(rx_timeout),  32'(0));
  endtask

  // One clock: check at negedge, drive inputs, advance the model across the next posedge
  task automatic cycle(input bit done, input bit cs, input logic [7:0] d, input bit rdy, input bit clr);
    bit pop;
    bit acc;
    bit good;
    @(negedge clk);
    check_outputs();
    rx_done_tick  = done;
    correct_send  = cs;
    rx_data       = d;
    bus.m_ready   = rdy;
    clr_status    = clr;
    pop = (mq.size() != 0) && rdy;
    acc = pend && ((mq.size() < DEPTH) || pop);
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(pend_e);
    if (clr) begin
      m_fcnt = 0;
      m_pcnt = 0;
      m_ovr  = 1'b0;
    end else if (acc) begin
      if (m_fcnt < 65535) m_fcnt++;
      if (pend_e[8] && m_pcnt < 255) m_pcnt++;
    end else if (pend) begin
      m_ovr = 1'b1;
    end
    good   = cs || seen_cs;
    pend   = done;
    pend_e = {~good, d};
    if (done)    seen_cs = 1'b0;
    else if (cs) seen_cs = 1'b1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, rdy, 1'b0);
  endtask

  // Optional correct_send, then rx_done_tick, then the commit cycle
  task automatic frame(input bit good, input logic [7:0] d, input bit rdy);
    if (good) cycle(1'b0, 1'b1, 8'h00, rdy, 1'b0);
    cycle(1'b1, 1'b0, d, rdy, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, rdy, 1'b0);
  endtask

  // Observe post-edge state without letting an extra cycle pass
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Reset        = 1'b1;
    rx_done_tick = 1'b0;
    correct_send = 1'b0;
    clr_status   = 1'b0;
    bus.m_ready  = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    check_reset("rst");
    Reset = 1'b0;
  endtask

  // Each period after a tick lasts (baud_div sampled at that tick's wrap) + 1 clocks
  task automatic baud_test();
    int since;
    int exp_p;
    int ticks;
    bit have;
    enable   = 1'b0;
    baud_div = DIV_W'(3);
    repeat (2) @(negedge clk);
    enable = 1'b1;
    have   = 1'b0;
    since  = 0;
    ticks  = 0;
    exp_p  = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      since++;
      if (s_ticks) begin
        if (have) check_eq("tick_period", 32'(since), 32'(exp_p));
        exp_p = int'(baud_div) + 1;
        since = 0;
        have  = 1'b1;
        ticks++;
      end else if (ticks == 3 && since == 2) begin
        baud_div = DIV_W'(1);
      end
      if (ticks > 8 && $urandom_range(0, 5) == 0) baud_div = DIV_W'($urandom_range(0, 6));
    end
    check_eq("tick_count_min", 32'(ticks >= 40), 32'(1));
    enable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("tick_disabled", 32'(s_ticks), 32'(0));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset        = 1'b1;
    enable       = 1'b0;
    baud_div     = '0;
    clr_status   = 1'b0;
    rx_done_tick = 1'b0;
    correct_send = 1'b0;
    rx_data      = '0;
    bus.m_ready  = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    check_reset("por");
    Reset = 1'b0;

    baud_test();

    enable   = 1'b1;
    baud_div = DIV_W'(2);

    // Good frame, latency and payload
    frame(1'b1, 8'hA5, 1'b1);
    settle();
    check_eq("t2_valid", 32'(bus.m_valid), 32'(1));
    check_eq("t2_data",  32'(bus.m_data),  32'(8'hA5));
    check_eq("t2_perr",  32'(bus.m_perr),  32'(0));
    check_eq("t2_fcnt",  32'(frame_cnt),   32'(1));
    idle(2, 1'b1);

    // Done without correct_send is a parity error
    frame(1'b0, 8'h3C, 1'b1);
    settle();
    check_eq("t3_data", 32'(bus.m_data), 32'(8'h3C));
    check_eq("t3_perr", 32'(bus.m_perr), 32'(1));
    check_eq("t3_pcnt", 32'(perr_cnt),   32'(1));
    idle(2, 1'b1);

    // Nine frames into an eight-deep FIFO with no consumer
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) frame(1'b1, 8'(i * 29 + 1), 1'b0);
    settle();
    check_eq("t4_fcnt",    32'(frame_cnt), 32'(8));
    check_eq("t4_overrun", 32'(overrun),   32'(1));
    idle(12, 1'b1);
    settle();
    check_eq("t4_drained", 32'(bus.m_valid), 32'(0));

    // Full FIFO: simultaneous push and pop, then clear alongside a commit
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) frame(1'b1, 8'(i + 8'h40), 1'b0);
    cycle(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    settle();
    check_eq("t5_overrun", 32'(overrun),   32'(0));
    check_eq("t5_fcnt",    32'(frame_cnt), 32'(9));
    cycle(1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    settle();
    check_eq("t5_clr_fcnt", 32'(frame_cnt), 32'(0));
    check_eq("t5_clr_pcnt", 32'(perr_cnt),  32'(0));
    idle(12, 1'b1);

    // Randomized traffic, light then heavy back-pressure
    for (int c = 0; c < 800; c++) begin
      cycle($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, 8'($urandom),
            (c < 400) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 4) == 0),
            $urandom_range(0, 79) == 0);
    end
    idle(12, 1'b1);

    // Back-to-back bad frames saturate perr_cnt
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 270; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b1, 1'b0);
    idle(3, 1'b1);
    settle();
    check_eq("sat_pcnt", 32'(perr_cnt),  32'(255));
    check_eq("sat_fcnt", 32'(frame_cnt), 32'(270));
    idle(2, 1'b1);

    // Reset in the middle of a frame discards everything
    frame(1'b1, 8'h11, 1'b0);
    frame(1'b1, 8'h22, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 1'b0, 8'h44, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    settle();
    check_eq("post_rst_perr", 32'(bus.m_perr), 32'(1));
    idle(3, 1'b1);

`ifdef UART_RX_TIMEOUT_EN
    begin
      int wait_n;
      baud_div = DIV_W'(0);
      frame(1'b1, 8'h77, 1'b0);
      wait_n = 40;
      for (int i = 0; i < 40; i++) begin
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        settle();
        if (rx_timeout) begin
          wait_n = i;
          break;
        end
      end
      check_eq("to_rise", 32'(rx_timeout), 32'(1));
      check_eq("to_delay_in_window", 32'(wait_n >= int'(TO_TICKS) && wait_n <= int'(TO_TICKS) + 2), 32'(1));
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      settle();
      check_eq("to_clear_on_pop", 32'(rx_timeout), 32'(0));
      idle(3, 1'b1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
